fifo_buffer_param: RTL

//  Parametrised synchronous FIFO; the next-generation FIFObuffer with configurable width/depth.

---
 rtl/fifo_buffer_param_pkg.sv | 24 ++
 rtl/fifo_mem_dp.sv | 26 ++
 rtl/fifo_buffer_param.sv | 123 ++++++++++++
 3 files changed

// File: rtl/fifo_buffer_param_pkg.sv
// Shared constants and elaboration helpers for the parametrised FIFO.
// Holds the read-mode encodings and the address-width math used by the top and memory.
package fifo_buffer_param_pkg;

    localparam int MODE_STD  = 0;
    localparam int MODE_FWFT = 1;

    // Smallest r such that 2**r >= value; used for pointer and count widths.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic bit is_pow2(input int value);
        return (value >= 2) && ((value & (value - 1)) == 0);
    endfunction

endpackage

// File: rtl/fifo_mem_dp.sv
// DEPTH x DATA_W register array: one synchronous write port, one asynchronous read port.
// No reset; contents are only meaningful where the pointers say they are.
module fifo_mem_dp #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int AW     = 3
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [AW-1:0]     i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fifo_buffer_param.sv
// Parametrised single-clock FIFO with occupancy count, threshold flags, error pulses,
// a global enable and an optional first-word-fall-through read mode.
module fifo_buffer_param
    import fifo_buffer_param_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 8,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2,
    parameter int FWFT      = MODE_STD
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   we,
    input  logic                   re,
    input  logic [DATA_W-1:0]      data_in,
    output logic [DATA_W-1:0]      data_out,
    output logic                   Empty,
    output logic                   Full,
    output logic                   AlmostEmpty,
    output logic                   AlmostFull,
    output logic [clog2(DEPTH):0]  count,
    output logic                   Overflow,
    output logic                   Underflow
);

    localparam int AW = clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C   = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C   = CW'(AE_THRESH);
    localparam bit IS_FWFT = (FWFT == MODE_FWFT);

    if (DATA_W < 1) begin : g_chk_width
        $error("fifo_buffer_param: DATA_W must be >= 1");
    end
    if (!is_pow2(DEPTH)) begin : g_chk_depth
        $error("fifo_buffer_param: DEPTH must be a power of 2 and >= 2");
    end
    if (!(AE_THRESH < AF_THRESH && AF_THRESH <= DEPTH)) begin : g_chk_thresh
        $error("fifo_buffer_param: thresholds must satisfy AE_THRESH < AF_THRESH <= DEPTH");
    end

    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic [DATA_W-1:0] r_data_out;
    logic              r_overflow;
    logic              r_underflow;

    logic              w_empty;
    logic              w_full;
    logic              w_wr_ok;
    logic              w_rd_ok;
    logic [CW-1:0]     w_count_next;
    logic [DATA_W-1:0] w_rd_data;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FULL_C);

    // A full FIFO still accepts a write when the same edge frees a slot by reading.
    assign w_wr_ok = we & (~w_full | re);
    assign w_rd_ok = re & ~w_empty;

    always_comb begin
        w_count_next = r_count;
        case ({w_wr_ok, w_rd_ok})
            2'b10:   w_count_next = r_count + CW'(1);
            2'b01:   w_count_next = r_count - CW'(1);
            default: w_count_next = r_count;
        endcase
    end

    fifo_mem_dp #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clk     (clk),
        .i_we    (en & w_wr_ok),
        .i_waddr (r_wr_ptr),
        .i_wdata (data_in),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rd_data)
    );

    // r_data_out is the read register in standard mode and the last-popped word in FWFT mode.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_data_out  <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (!en) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd_ok) begin
                r_rd_ptr   <= r_rd_ptr + AW'(1);
                r_data_out <= w_rd_data;
            end
            r_count     <= w_count_next;
            r_overflow  <= we & ~w_wr_ok;
            r_underflow <= re & ~w_rd_ok;
        end
    end

    assign data_out    = (IS_FWFT && !w_empty) ? w_rd_data : r_data_out;
    assign Empty       = w_empty;
    assign Full        = w_full;
    assign AlmostEmpty = (r_count <= AE_C);
    assign AlmostFull  = (r_count >= AF_C);
    assign count       = r_count;
    assign Overflow    = r_overflow;
    assign Underflow   = r_underflow;

endmodule
